// File: rtl/otter_mmio_hub.sv
// otter_mmio_hub: memory-mapped IO hub between the OTTER IOBUS and board peripherals.
//   Optional build macro: MMIO_READBACK_EN (output slots read back their register value).
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   IOBUS_ADDR/OUT/WR CPU address, write data, one-cycle write strobe
//   IOBUS_IN          combinational read data, decoded from IOBUS_ADDR
//   IN_DATA           N_IN asynchronous input channels, DATA_W bits each
//   BTN               N_BTN raw buttons (debounced, rising edge -> pending)
//   OUT_DATA          N_OUT registered output channels
//   INTR              registered interrupt request, |(pending & mask)
// Map (offsets from BASE_AD): inputs 0x000+4i, outputs 0x100+4j,
//   INT_PEND 0x200 (write-1-to-clear), INT_MASK 0x204.
module otter_mmio_hub #(
   parameter logic [31:0] BASE_AD   = 32'h1100_0000,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned N_IN      = 2,
   parameter int unsigned N_OUT     = 4,
   parameter int unsigned N_BTN     = 2,
   parameter int unsigned DB_CYCLES = 500000
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [31:0]             IOBUS_ADDR,
   input  logic [31:0]             IOBUS_OUT,
   input  logic                    IOBUS_WR,
   output logic [31:0]             IOBUS_IN,
   input  logic [N_IN*DATA_W-1:0]  IN_DATA,
   input  logic [N_BTN-1:0]        BTN,
   output logic [N_OUT*DATA_W-1:0] OUT_DATA,
   output logic                    INTR
);

   localparam int unsigned CNT_W    = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);
   localparam logic [31:0] OFF_OUT  = 32'h0000_0100;
   localparam logic [31:0] OFF_PEND = 32'h0000_0200;
   localparam logic [31:0] OFF_MASK = 32'h0000_0204;

   logic [N_IN*DATA_W-1:0]  r_in_s1, r_in_s2;
   logic [N_OUT*DATA_W-1:0] r_out;
   logic [N_BTN-1:0]        r_btn_s1, r_btn_s2, r_btn_db;
   logic [CNT_W-1:0]        r_db_cnt [N_BTN];
   logic [N_BTN-1:0]        r_pend, r_mask;
   logic                    r_intr;

   logic [31:0]      w_off, w_out_off;
   logic             w_aligned, w_in_hit, w_out_hit;
   logic [3:0]       w_in_idx, w_out_idx;
   logic             w_wr_pend, w_wr_mask;
   logic [N_BTN-1:0] w_db_term, w_rise, w_w1c;
   logic [N_BTN-1:0] w_pend_next, w_mask_next;
   logic [31:0]      w_rdata;
   logic             w_unused_bits;

   // Address decode relative to the window base; wrap-around keeps low addresses unmapped
   assign w_off      = IOBUS_ADDR - BASE_AD;
   assign w_out_off  = w_off - OFF_OUT;
   assign w_aligned  = (w_off[1:0] == 2'b00);
   assign w_in_hit   = w_aligned && (w_off[31:2] < 30'(N_IN));
   assign w_out_hit  = w_aligned && (w_out_off[31:2] < 30'(N_OUT));
   assign w_in_idx   = w_off[5:2];
   assign w_out_idx  = w_out_off[5:2];
   assign w_wr_pend  = IOBUS_WR && (w_off == OFF_PEND);
   assign w_wr_mask  = IOBUS_WR && (w_off == OFF_MASK);

   // Upper write-data bits and high offset bits are intentionally ignored
   assign w_unused_bits = ^{IOBUS_OUT, w_off, w_out_off};

   // Input synchronisers
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_in_s1 <= '0;
         r_in_s2 <= '0;
      end else begin
         r_in_s1 <= IN_DATA;
         r_in_s2 <= r_in_s1;
      end
   end

   // Output channel registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_out <= '0;
      end else begin
         for (int j = 0; j < N_OUT; j++) begin
            if (IOBUS_WR && w_out_hit && (w_out_idx == 4'(j)))
               r_out[j*DATA_W +: DATA_W] <= IOBUS_OUT[DATA_W-1:0];
         end
      end
   end

   // Debounce: count while the synchronised level disagrees with the accepted level;
   // any return to agreement restarts the count, so only a stable change is accepted
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_btn_s1 <= '0;
         r_btn_s2 <= '0;
         r_btn_db <= '0;
         for (int k = 0; k < N_BTN; k++) r_db_cnt[k] <= '0;
      end else begin
         r_btn_s1 <= BTN;
         r_btn_s2 <= r_btn_s1;
         for (int k = 0; k < N_BTN; k++) begin
            if (r_btn_s2[k] == r_btn_db[k]) begin
               r_db_cnt[k] <= '0;
            end else if (w_db_term[k]) begin
               r_db_cnt[k] <= '0;
               r_btn_db[k] <= r_btn_s2[k];
            end else begin
               r_db_cnt[k] <= r_db_cnt[k] + CNT_W'(1);
            end
         end
      end
   end

   // Accept point and debounced rising edge per button
   always_comb begin
      w_db_term = '0;
      for (int k = 0; k < N_BTN; k++)
         w_db_term[k] = (r_btn_s2[k] != r_btn_db[k]) && (r_db_cnt[k] == CNT_TERM);
   end

   assign w_rise      = w_db_term & r_btn_s2 & ~r_btn_db;
   assign w_w1c       = w_wr_pend ? IOBUS_OUT[N_BTN-1:0] : '0;
   // A new edge in the same cycle as its clear wins
   assign w_pend_next = (r_pend & ~w_w1c) | w_rise;
   assign w_mask_next = w_wr_mask ? IOBUS_OUT[N_BTN-1:0] : r_mask;

   // Interrupt state
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pend <= '0;
         r_mask <= '0;
         r_intr <= 1'b0;
      end else begin
         r_pend <= w_pend_next;
         r_mask <= w_mask_next;
         r_intr <= |(w_pend_next & w_mask_next);
      end
   end

   // Read mux
   always_comb begin
      w_rdata = 32'h0;
      for (int i = 0; i < N_IN; i++) begin
         if (w_in_hit && (w_in_idx == 4'(i)))
            w_rdata = 32'(r_in_s2[i*DATA_W +: DATA_W]);
      end
`ifdef MMIO_READBACK_EN
      for (int j = 0; j < N_OUT; j++) begin
         if (w_out_hit && (w_out_idx == 4'(j)))
            w_rdata = 32'(r_out[j*DATA_W +: DATA_W]);
      end
`else
      // Output slots read as zero
`endif
      if (w_off == OFF_PEND) w_rdata = 32'(r_pend);
      if (w_off == OFF_MASK) w_rdata = 32'(r_mask);
   end

   assign IOBUS_IN = w_rdata;
   assign OUT_DATA = r_out;
   assign INTR     = r_intr;

endmodule
